mem_arbiter: RTL
================

# mem_arbiter

Shares one unified memory port between the core's instruction-fetch requester and data-access requester. It sits between the core's im/dm ports and the external memory, and uses a three-state controller:

- Data accesses have priority, with starvation protection for fetch.
- Each request/response pair is serialised through the memory handshake.
- A watchdog aborts accesses that the memory never acknowledges.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive dm grants taken while im waits; after this many, the next grant goes to im.
- TIMEOUT, 255: cycles in a grant state without mem_ack_i before the access is aborted (8-bit counter).

Ports (clock and reset first):
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- im_req_i  in  1  fetch request (level); held until im_valid_o is seen.
- im_addr_i  in  32  fetch address.
- im_busy_o  out  1  = im_req_i & ~im_valid_o.
- im_valid_o  out  1  one-cycle response strobe.
- im_dout_o  out  32  fetched instruction, valid with im_valid_o.
- dm_en_i  in  1  data request (level).
- dm_wen_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  32  data address.
- dm_din_i  in  32  write data.
- dm_busy_o  out  1  = dm_en_i & ~dm_valid_o.
- dm_valid_o  out  1  one-cycle response strobe; pulses for reads and for writes.
- dm_dout_o  out  32  read data, valid with dm_valid_o.
- mem_en_o  out  1  memory request, held until acked.
- mem_wen_o  out  1  write enable.
- mem_addr_o  out  32  memory address.
- mem_din_o  out  32  memory write data.
- mem_dout_i  in  32  memory read data, valid in the mem_ack_i cycle.
- mem_ack_i  in  1  memory completion strobe.
- err_o  out  1  sticky timeout flag.

## Operation
States: IDLE, GRANT_IM, GRANT_DM, RESP.

IDLE:
- If dm_en_i is high and (starve_cnt < STARVE_LIMIT or im_req_i is low): go to GRANT_DM. Latch dm_addr_i, dm_din_i and dm_wen_i into the mem_* registers.
- Otherwise, if im_req_i is high: go to GRANT_IM. Latch im_addr_i; mem_wen_o = 0.
- Otherwise: stay in IDLE.

GRANT_x:
- mem_en_o = 1. Address, data and wen stay stable for the whole state.
- On mem_ack_i: capture mem_dout_i into the x_dout_o register (reads only; a write leaves dm_dout_o unchanged), then go to RESP.
- If the wait count reaches TIMEOUT without an ack: set err_o, load x_dout_o = 32'h0, then go to RESP.

RESP:
- The valid strobe of the granted requester is high.
- mem_en_o = 0.
- No new grant is made in RESP, which prevents re-granting a still-asserted old request.
- Always goes to IDLE next.

Starvation counter (starve_cnt, 3 bits, saturating):
- On a dm grant with im_req_i high: increment.
- On any im grant, or a dm grant with im_req_i low: clear to 0.

Watchdog counter:
- Cleared on entry to either GRANT state.
- Increments each cycle in a GRANT state.

Upstream handshake rule: a requester must drop its request, or present a new one, in the cycle after its valid strobe. The request it presents in that cycle is sampled in IDLE.

Boundary conditions:
- Simultaneous im/dm requests with starve_cnt < STARVE_LIMIT: dm wins.
- Simultaneous requests with starve_cnt == STARVE_LIMIT: im wins.
- mem_ack_i outside a GRANT state is ignored.
- A request dropped while granted: the access still completes and the strobe still pulses.
- Reset mid-access: the state goes to IDLE at that edge. An ack arriving later is ignored.

## Timing
Reset values of outputs:
- mem_en_o, mem_wen_o, im_valid_o, dm_valid_o, err_o = 0.
- All 32-bit outputs = 0.
- starve_cnt = 0, watchdog = 0.

Cycle-level latency:
- Request sampled in IDLE at cycle N: mem_en_o = 1 at N+1.
- mem_ack_i at cycle M (M ≥ N+1): the valid strobe and data appear at M+1 (RESP), and the arbiter is back in IDLE at M+2.
- With zero-wait memory, throughput is 1 access per 3 cycles.
- Timeout: aborts after TIMEOUT cycles in GRANT; the valid strobe follows one cycle later.

All outputs are registered except im_busy_o and dm_busy_o, which are combinational.

## Structure
Shared package core_pkg holds:
- the enum arb_state_e (IDLE, GRANT_IM, GRANT_DM, RESP);
- XLEN = 32;
- TIMEOUT_DATA = 32'h0.

There is no sub-module. The starvation counter and watchdog counter are inline in mem_arbiter; the FSM is a single always_ff plus next-state logic.

## Test plan
- im_req_i=1, im_addr_i=0x100; memory acks 2 cycles after mem_en_o with data 0x00500093: mem_addr_o=0x100 at N+1; im_valid_o=1 with im_dout_o=0x00500093 at ack+1; im_busy_o=0 in that cycle.
- dm write with dm_addr_i=0x2000, dm_din_i=0xA5A5A5A5, and im_req_i high in the same cycle: dm is granted first with mem_wen_o=1; dm_valid_o pulses; im is granted in the next IDLE.
- dm_en_i and im_req_i held high continuously, 0-wait memory: the grant order is dm×4, im, dm×4, im; no overlap of valid strobes.
- mem_ack_i never arrives on a dm read: after 255 GRANT cycles, dm_valid_o=1 with dm_dout_o=0 and err_o=1; err_o stays 1 until rst_i.
- rst_i asserted one cycle after grant, then mem_ack_i pulsed: mem_en_o=0 after that edge, no valid strobe, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory-side blocks.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] TIMEOUT_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IM = 2'd1,
        GRANT_DM = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one memory port: data first,
// bounded fetch starvation, and a watchdog that aborts unacknowledged accesses.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            im_req_i,
    input  logic [XLEN-1:0] im_addr_i,
    output logic            im_busy_o,
    output logic            im_valid_o,
    output logic [XLEN-1:0] im_dout_o,
    input  logic            dm_en_i,
    input  logic            dm_wen_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_din_i,
    output logic            dm_busy_o,
    output logic            dm_valid_o,
    output logic [XLEN-1:0] dm_dout_o,
    output logic            mem_en_o,
    output logic            mem_wen_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_din_o,
    input  logic [XLEN-1:0] mem_dout_i,
    input  logic            mem_ack_i,
    output logic            err_o
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic [2:0]      starve_cnt_q, starve_cnt_d;
    logic [7:0]      wd_cnt_q, wd_cnt_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_wen_q, mem_wen_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_din_q, mem_din_d;
    logic            im_valid_q, im_valid_d;
    logic            dm_valid_q, dm_valid_d;
    logic [XLEN-1:0] im_dout_q, im_dout_d;
    logic [XLEN-1:0] dm_dout_q, dm_dout_d;
    logic            err_q, err_d;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'h7) ? v : v + 3'h1;
    endfunction

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        mem_en_d     = mem_en_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        im_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        im_dout_d    = im_dout_q;
        dm_dout_d    = dm_dout_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (dm_en_i && ((starve_cnt_q < STARVE_MAX) || !im_req_i)) begin
                    state_d      = GRANT_DM;
                    mem_en_d     = 1'b1;
                    mem_wen_d    = dm_wen_i;
                    mem_addr_d   = dm_addr_i;
                    mem_din_d    = dm_din_i;
                    wd_cnt_d     = 8'd0;
                    starve_cnt_d = im_req_i ? sat_inc3(starve_cnt_q) : 3'd0;
                end else if (im_req_i) begin
                    state_d      = GRANT_IM;
                    mem_en_d     = 1'b1;
                    mem_wen_d    = 1'b0;
                    mem_addr_d   = im_addr_i;
                    wd_cnt_d     = 8'd0;
                    starve_cnt_d = 3'd0;
                end
            end
            GRANT_IM, GRANT_DM: begin
                if (mem_ack_i) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    if (state_q == GRANT_IM) begin
                        im_valid_d = 1'b1;
                        im_dout_d  = mem_dout_i;
                    end else begin
                        dm_valid_d = 1'b1;
                        // A write completion keeps the last read data visible.
                        if (!mem_wen_q) dm_dout_d = mem_dout_i;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    err_d    = 1'b1;
                    if (state_q == GRANT_IM) begin
                        im_valid_d = 1'b1;
                        im_dout_d  = TIMEOUT_DATA;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_dout_d  = TIMEOUT_DATA;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            // No grant here: the requester may still hold the request just served.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= 3'd0;
            wd_cnt_q     <= 8'd0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            im_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            im_dout_q    <= '0;
            dm_dout_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            im_valid_q   <= im_valid_d;
            dm_valid_q   <= dm_valid_d;
            im_dout_q    <= im_dout_d;
            dm_dout_q    <= dm_dout_d;
            err_q        <= err_d;
        end
    end

    assign im_busy_o  = im_req_i & ~im_valid_q;
    assign dm_busy_o  = dm_en_i & ~dm_valid_q;
    assign im_valid_o = im_valid_q;
    assign dm_valid_o = dm_valid_q;
    assign im_dout_o  = im_dout_q;
    assign dm_dout_o  = dm_dout_q;
    assign mem_en_o   = mem_en_q;
    assign mem_wen_o  = mem_wen_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;
    assign err_o      = err_q;

endmodule
